// File: rtl/myriscv_axi_slave_mem.sv
// AXI4 INCR burst slave backed by a word-addressed RAM.
// Independent write (AW/W/B) and read (AR/R) engines, one outstanding burst each.
module myriscv_axi_slave_mem #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 12,
    parameter int MEM_DEPTH_WORDS    = 256
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S00_AXI_AWADDR,
    input  logic [7:0]                      S00_AXI_AWLEN,
    input  logic                            S00_AXI_AWVALID,
    output logic                            S00_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S00_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S00_AXI_WSTRB,
    input  logic                            S00_AXI_WLAST,
    input  logic                            S00_AXI_WVALID,
    output logic                            S00_AXI_WREADY,
    output logic [1:0]                      S00_AXI_BRESP,
    output logic                            S00_AXI_BVALID,
    input  logic                            S00_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S00_AXI_ARADDR,
    input  logic [7:0]                      S00_AXI_ARLEN,
    input  logic                            S00_AXI_ARVALID,
    output logic                            S00_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S00_AXI_RDATA,
    output logic [1:0]                      S00_AXI_RRESP,
    output logic                            S00_AXI_RLAST,
    output logic                            S00_AXI_RVALID,
    input  logic                            S00_AXI_RREADY
);

    localparam int NB  = C_S_AXI_DATA_WIDTH / 8;
    // Word index carries one extra bit so a burst near the top never wraps back into range.
    localparam int IW  = C_S_AXI_ADDR_WIDTH - 1;
    localparam int MAW = $clog2(MEM_DEPTH_WORDS);
    localparam logic [IW-1:0] DEPTH = IW'(MEM_DEPTH_WORDS);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    logic [C_S_AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH_WORDS];

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{S00_AXI_AWADDR[1:0], S00_AXI_ARADDR[1:0]};

    // ---------------- write engine ----------------
    wstate_t       w_state, w_next;
    logic [IW-1:0] w_idx;
    logic [7:0]    w_len, w_beat;
    logic          w_err, w_err_next;
    logic          aw_hs, w_hs, b_hs, w_last_beat, w_oor;

    assign aw_hs       = S00_AXI_AWVALID & S00_AXI_AWREADY;
    assign w_hs        = S00_AXI_WVALID & S00_AXI_WREADY;
    assign b_hs        = S00_AXI_BVALID & S00_AXI_BREADY;
    assign w_last_beat = (w_beat == w_len);
    assign w_oor       = (w_idx >= DEPTH);

    always_comb begin
        w_next     = w_state;
        w_err_next = w_err;
        case (w_state)
            W_IDLE: if (aw_hs) begin
                w_next     = W_DATA;
                w_err_next = 1'b0;
            end
            W_DATA: if (w_hs) begin
                // Beat count comes from AWLEN; a misplaced WLAST only flags the error.
                w_err_next = w_err | w_oor | (S00_AXI_WLAST != w_last_beat);
                if (w_last_beat) w_next = W_RESP;
            end
            W_RESP: if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            w_state         <= W_IDLE;
            w_idx           <= '0;
            w_len           <= '0;
            w_beat          <= '0;
            w_err           <= 1'b0;
            S00_AXI_AWREADY <= 1'b0;
            S00_AXI_WREADY  <= 1'b0;
            S00_AXI_BVALID  <= 1'b0;
            S00_AXI_BRESP   <= 2'b00;
        end else begin
            w_state         <= w_next;
            w_err           <= w_err_next;
            S00_AXI_AWREADY <= (w_next == W_IDLE);
            S00_AXI_WREADY  <= (w_next == W_DATA);
            S00_AXI_BVALID  <= (w_next == W_RESP);
            S00_AXI_BRESP   <= {(w_next == W_RESP) & w_err_next, 1'b0};
            if (aw_hs) begin
                w_idx  <= {1'b0, S00_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2]};
                w_len  <= S00_AXI_AWLEN;
                w_beat <= '0;
            end else if (w_hs) begin
                w_idx  <= w_idx + 1'b1;
                w_beat <= w_beat + 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESETN && w_hs && !w_oor) begin
            for (int b = 0; b < NB; b++) begin
                if (S00_AXI_WSTRB[b])
                    mem[w_idx[MAW-1:0]][8*b +: 8] <= S00_AXI_WDATA[8*b +: 8];
            end
        end
    end

    // ---------------- read engine ----------------
    rstate_t                       r_state, r_next;
    logic [IW-1:0]                 r_idx, f_idx;
    logic [7:0]                    r_len, r_beat;
    logic                          ar_hs, r_hs, r_last_beat, f_oor;
    logic [C_S_AXI_DATA_WIDTH-1:0] f_data;

    assign ar_hs       = S00_AXI_ARVALID & S00_AXI_ARREADY;
    assign r_hs        = S00_AXI_RVALID & S00_AXI_RREADY;
    assign r_last_beat = (r_beat == r_len);

    // f_idx is the word to present next: burst start when idle, else the following word.
    always_comb begin
        r_next = r_state;
        f_idx  = r_idx + 1'b1;
        case (r_state)
            R_IDLE: begin
                f_idx = {1'b0, S00_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]};
                if (ar_hs) r_next = R_DATA;
            end
            R_DATA: if (r_hs && r_last_beat) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
        f_oor  = (f_idx >= DEPTH);
        f_data = f_oor ? '0 : mem[f_idx[MAW-1:0]];
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state         <= R_IDLE;
            r_idx           <= '0;
            r_len           <= '0;
            r_beat          <= '0;
            S00_AXI_ARREADY <= 1'b0;
            S00_AXI_RVALID  <= 1'b0;
            S00_AXI_RLAST   <= 1'b0;
            S00_AXI_RDATA   <= '0;
            S00_AXI_RRESP   <= 2'b00;
        end else begin
            r_state         <= r_next;
            S00_AXI_ARREADY <= (r_next == R_IDLE);
            if (ar_hs) begin
                r_idx          <= f_idx;
                r_len          <= S00_AXI_ARLEN;
                r_beat         <= '0;
                S00_AXI_RDATA  <= f_data;
                S00_AXI_RRESP  <= {f_oor, 1'b0};
                S00_AXI_RLAST  <= (S00_AXI_ARLEN == 8'd0);
                S00_AXI_RVALID <= 1'b1;
            end else if (r_hs) begin
                if (r_last_beat) begin
                    S00_AXI_RVALID <= 1'b0;
                    S00_AXI_RLAST  <= 1'b0;
                end else begin
                    r_idx         <= f_idx;
                    r_beat        <= r_beat + 1'b1;
                    S00_AXI_RDATA <= f_data;
                    S00_AXI_RRESP <= {f_oor, 1'b0};
                    S00_AXI_RLAST <= ((r_beat + 8'd1) == r_len);
                end
            end
        end
    end

endmodule

// File: tb/tb_myriscv_axi_slave_mem.sv
// Bench for myriscv_axi_slave_mem: constant vector table, directed corner sequences,
// and random bursts checked against a word-array memory model.
module tb_myriscv_axi_slave_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rlast, rvalid, rready;

    always #5 clk = ~clk;

    myriscv_axi_slave_mem dut (
        .ACLK(clk), .ARESETN(rst_n),
        .S00_AXI_AWADDR(awaddr), .S00_AXI_AWLEN(awlen), .S00_AXI_AWVALID(awvalid),
        .S00_AXI_AWREADY(awready), .S00_AXI_WDATA(wdata), .S00_AXI_WSTRB(wstrb),
        .S00_AXI_WLAST(wlast), .S00_AXI_WVALID(wvalid), .S00_AXI_WREADY(wready),
        .S00_AXI_BRESP(bresp), .S00_AXI_BVALID(bvalid), .S00_AXI_BREADY(bready),
        .S00_AXI_ARADDR(araddr), .S00_AXI_ARLEN(arlen), .S00_AXI_ARVALID(arvalid),
        .S00_AXI_ARREADY(arready), .S00_AXI_RDATA(rdata), .S00_AXI_RRESP(rresp),
        .S00_AXI_RLAST(rlast), .S00_AXI_RVALID(rvalid), .S00_AXI_RREADY(rready)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] model_mem [256];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_bresp;
        logic [1:0]  exp_rresp;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_rd(input int idx);
        return (idx < 256) ? model_mem[idx] : 32'h0;
    endfunction

    // Drives one write burst from wd/ws; updates the model; returns actual and expected BRESP.
    task automatic axi_write(input logic [11:0] addr, input logic [7:0] len, input int wlast_at,
                             input int gap_pct, output logic [1:0] got, output logic [1:0] exp);
        int guard;
        int idx;
        bit err;
        err = 0;
        awaddr = addr; awlen = len; awvalid = 1'b1;
        guard = 0;
        while (!awready && guard < 50) begin @(negedge clk); guard++; end
        if (!awready) chk("awready_timeout", awready, 1);
        @(negedge clk);
        awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            while ($urandom_range(99) < gap_pct) begin wvalid = 1'b0; @(negedge clk); end
            wdata = wd[b]; wstrb = ws[b]; wlast = (b == wlast_at); wvalid = 1'b1;
            guard = 0;
            while (!wready && guard < 50) begin @(negedge clk); guard++; end
            if (!wready) chk("wready_timeout", wready, 1);
            @(negedge clk);
            idx = int'(addr[11:2]) + b;
            if (idx >= 256) err = 1;
            else for (int l = 0; l < 4; l++) if (ws[b][l]) model_mem[idx][8*l +: 8] = wd[b][8*l +: 8];
            if ((b == wlast_at) != (b == int'(len))) err = 1;
            if (b != int'(len)) chk("bvalid_early", bvalid, 0);
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk("bvalid_after_last", bvalid, 1);
        got = bresp;
        exp = err ? 2'b10 : 2'b00;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk("bvalid_clear", bvalid, 0);
        chk("awready_back", awready, 1);
    endtask

    // Read burst with random RREADY stalls; every cycle of every beat is checked against the model.
    task automatic axi_read(input logic [11:0] addr, input logic [7:0] len, input int stall_pct);
        int guard;
        int idx;
        bit go;
        araddr = addr; arlen = len; arvalid = 1'b1;
        guard = 0;
        while (!arready && guard < 50) begin @(negedge clk); guard++; end
        if (!arready) chk("arready_timeout", arready, 1);
        @(negedge clk);
        arvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            idx = int'(addr[11:2]) + b;
            guard = 0;
            forever begin
                chk($sformatf("rvalid[%0d]", b), rvalid, 1);
                chk($sformatf("rdata[%0d]", b), rdata, model_rd(idx));
                chk($sformatf("rresp[%0d]", b), rresp, (idx >= 256) ? 2'b10 : 2'b00);
                chk($sformatf("rlast[%0d]", b), rlast, (b == int'(len)));
                go = ($urandom_range(99) >= stall_pct) || (guard >= 20);
                rready = go;
                @(negedge clk);
                if (go) break;
                guard++;
            end
        end
        rready = 1'b0;
        chk("rvalid_end", rvalid, 0);
        chk("rlast_end", rlast, 0);
    endtask

    task automatic read1(input logic [11:0] addr, output logic [31:0] d, output logic [1:0] r,
                         output logic l);
        int guard;
        araddr = addr; arlen = 8'd0; arvalid = 1'b1;
        guard = 0;
        while (!arready && guard < 50) begin @(negedge clk); guard++; end
        if (!arready) chk("arready_timeout", arready, 1);
        @(negedge clk);
        arvalid = 1'b0;
        d = rdata; r = rresp; l = rlast;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [1:0]  br, ebr, rr;
        logic [31:0] rd;
        logic        rl;
        logic [11:0] a;
        logic [7:0]  ln;
        int          wl;

        tbl[0] = '{12'h010, 32'hFFFFFFFF, 4'hF, 32'hFFFFFFFF, 2'b00, 2'b00};
        tbl[1] = '{12'h010, 32'h12345678, 4'h5, 32'hFF34FF78, 2'b00, 2'b00};
        tbl[2] = '{12'h022, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 2'b00, 2'b00};
        tbl[3] = '{12'h020, 32'h000000AA, 4'h1, 32'hDEADBEAA, 2'b00, 2'b00};
        tbl[4] = '{12'h800, 32'h13579BDF, 4'hF, 32'h00000000, 2'b10, 2'b10};
        tbl[5] = '{12'h3FC, 32'h55AA55AA, 4'hA, 32'h55DE55FF, 2'b00, 2'b00};
        tbl[6] = '{12'h000, 32'h11223344, 4'h0, 32'hC0DE0000, 2'b00, 2'b00};
        tbl[7] = '{12'h007, 32'hAABBCCDD, 4'hC, 32'hAABB0001, 2'b00, 2'b00};

        rst_n = 1'b0;
        awaddr = '0; awlen = '0; awvalid = 1'b1;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arlen = '0; arvalid = 1'b1; rready = 1'b0;

        // T1: reset held with valids asserted
        repeat (20) @(negedge clk);
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_arready", arready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_rdata", rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_awready", awready, 1);
        chk("rel_arready", arready, 1);
        awvalid = 1'b0; arvalid = 1'b0;

        // Fill the whole memory with one maximum-length burst
        for (int i = 0; i < 256; i++) begin wd[i] = 32'hC0DE0000 | i; ws[i] = 4'hF; end
        axi_write(12'h000, 8'd255, 255, 0, br, ebr);
        chk("init_bresp", br, 2'b00);

        // Table-driven single-beat write then read-back
        foreach (tbl[i]) begin
            wd[0] = tbl[i].data; ws[0] = tbl[i].strb;
            axi_write(tbl[i].addr, 8'd0, 0, 0, br, ebr);
            chk($sformatf("tbl%0d_bresp", i), br, tbl[i].exp_bresp);
            read1(tbl[i].addr, rd, rr, rl);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_data);
            chk($sformatf("tbl%0d_rresp", i), rr, tbl[i].exp_rresp);
            chk($sformatf("tbl%0d_rlast", i), rl, 1);
        end

        // T2: 4-beat burst and read-back
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + i; ws[i] = 4'hF; end
        axi_write(12'h040, 8'd3, 3, 0, br, ebr);
        chk("t2_bresp", br, 2'b00);
        axi_read(12'h040, 8'd3, 0);
        read1(12'h04C, rd, rr, rl);
        chk("t2_word3", rd, 32'h000000A3);

        // T4: 8-beat read with heavy RREADY stalls
        axi_read(12'h100, 8'd7, 50);

        // T5: burst crossing the top of memory
        wd[0] = 32'h5A5A0001; wd[1] = 32'h5A5A0002; ws[0] = 4'hF; ws[1] = 4'hF;
        axi_write(12'h3FC, 8'd1, 1, 0, br, ebr);
        chk("t5_bresp", br, 2'b10);
        axi_read(12'h3FC, 8'd1, 30);
        read1(12'h3FC, rd, rr, rl);
        chk("t5_word255", rd, 32'h5A5A0001);

        // T6: early WLAST still takes AWLEN+1 beats and flags SLVERR
        for (int i = 0; i < 4; i++) begin wd[i] = 32'h66000000 + i; ws[i] = 4'hF; end
        axi_write(12'h080, 8'd3, 1, 0, br, ebr);
        chk("t6_bresp", br, 2'b10);
        read1(12'h08C, rd, rr, rl);
        chk("t6_word3", rd, 32'h66000003);

        // T6: reset in the middle of a read burst
        araddr = 12'h080; arlen = 8'd7; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0; rready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rready = 1'b0;
        chk("t6_mid_rvalid", rvalid, 1);
        chk("t6_mid_rdata", rdata, 32'h66000002);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_rvalid", rvalid, 0);
        chk("t6_rst_rdata", rdata, 0);
        chk("t6_rst_arready", arready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_rel_arready", arready, 1);
        read1(12'h080, rd, rr, rl);
        chk("t6_mem_kept", rd, 32'h66000000);

        // Random bursts against the model
        repeat (40) begin
            a  = 12'($urandom_range(0, 12'h47F));
            ln = 8'($urandom_range(0, 15));
            if ($urandom_range(1) == 1) begin
                for (int i = 0; i <= int'(ln); i++) begin
                    wd[i] = $urandom;
                    ws[i] = 4'($urandom_range(0, 15));
                end
                wl = ($urandom_range(9) == 0) ? int'($urandom_range(0, int'(ln))) : int'(ln);
                axi_write(a, ln, wl, 20, br, ebr);
                chk("rand_bresp", br, ebr);
            end else begin
                axi_read(a, ln, 30);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
